// File: rtl/toggle_cover_collector.sv
// Sticky toggle-cover bitmap that reports each newly fired point as an absolute index, lowest bit first.
// One cycle from hit to out_valid; out_ready=0 keeps reports in the pending bitmap, so none are lost.
module toggle_cover_collector #(
    parameter int WIDTH       = 9,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 28338,
    parameter int IDX_W       = 64,
    parameter int CNT_W       = 16,
    parameter int DEDUP       = 1
) (
    input  logic              gbl_clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  valid,
    input  logic              enable,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [CNT_W-1:0]  hit_count,
    output logic              all_hit,
    output logic [CNT_W-1:0]  merge_count
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("toggle_cover_collector: WIDTH must be 1..1024");
    end
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
        $error("toggle_cover_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt
        $error("toggle_cover_collector: CNT_W too narrow for WIDTH");
    end

    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] hits;
    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] low_oh;
    logic [WIDTH-1:0] pop;
    logic [WIDTH-1:0] seen_next;
    logic [WIDTH-1:0] merge_hits;
    logic [IW-1:0]    low_idx;
    logic [CNT_W:0]   merge_sum;
    logic [CNT_W-1:0] merge_next;

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Priority encode from the top down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IW'(i);
            end
        end
        low_oh = pending & (~pending + WIDTH'(1));
    end

    always_comb begin
        hits       = (enable && !clear) ? valid : '0;
        new_hits   = (DEDUP != 0) ? (hits & ~seen) : hits;
        pop        = (out_valid && out_ready) ? low_oh : '0;
        seen_next  = seen | hits;
        merge_hits = hits & pending & ~pop;
        merge_sum  = {1'b0, merge_count} + {1'b0, popcnt(merge_hits)};
        merge_next = merge_sum[CNT_W] ? {CNT_W{1'b1}} : merge_sum[CNT_W-1:0];
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            seen        <= '0;
            pending     <= '0;
            hit_count   <= '0;
            merge_count <= '0;
        end else if (clear) begin
            seen        <= '0;
            pending     <= '0;
            hit_count   <= '0;
            merge_count <= '0;
        end else begin
            seen      <= seen_next;
            pending   <= (pending & ~pop) | new_hits;
            hit_count <= popcnt(seen_next);
            if (DEDUP == 0) begin
                merge_count <= merge_next;
            end
        end
    end

    always_comb begin
        out_valid = |pending;
        out_index = out_valid ? (IDX_W'(COVER_INDEX) + IDX_W'(low_idx)) : '0;
        all_hit   = &seen;
    end

endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
- Parametrised successor to the per-width toggle cover stubs.
- Samples a WIDTH-bit toggle-hit vector every cycle and tracks which points have ever fired in a sticky bitmap.
- Queues newly fired points and reports them one at a time as absolute cover indices over a valid/ready stream.
- Sits between instrumented RTL and the coverage sink (DPI bridge or formal harness), so a single consumer can drain bursty multi-bit hits without losing any.

Parameters:
- WIDTH, 9: number of toggle cover points handled by this instance (1..1024).
- COVER_INDEX, 0: absolute index of bit 0; bit i reports as COVER_INDEX + i.
- COVER_TOTAL, 28338: total cover points in the design; used only for elaboration check COVER_INDEX + WIDTH <= COVER_TOTAL.
- IDX_W, 64: width of out_index.
- CNT_W, 16: width of hit_count and merge_count; elaboration check 2^CNT_W > WIDTH.
- DEDUP, 1:
  - 1 = report each point only on its first hit since reset/clear.
  - 0 = report every hit, with hits merged while a report for that point is still pending.

Ports:
- gbl_clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- valid  in  WIDTH  per-point hit strobes, sampled every cycle.
- enable  in  1  when 0, valid is ignored (no state update from hits).
- clear  in  1  synchronous re-arm: empties seen and pending, zeroes both counters.
- out_valid  out  1  a report is available.
- out_ready  in  1  consumer accepts the report.
- out_index  out  IDX_W  absolute cover index of the current report.
- hit_count  out  CNT_W  number of distinct points seen since reset/clear.
- all_hit  out  1  every point has been seen.
- merge_count  out  CNT_W  saturating count of hits merged into an already-pending report (DEDUP=0 only; constant 0 when DEDUP=1).

Behaviour:
- State registers: seen[WIDTH], pending[WIDTH], hit_count, merge_count.
- Reset (reset==0 at a gbl_clk edge):
  - All state is cleared on that edge.
  - From the following cycle: out_valid=0, out_index=0, hit_count=0, all_hit=0, merge_count=0.
  - Reset has priority over clear, valid and handshakes.
  - Reset mid-stream drops all pending reports; no partial report is issued afterwards.
- Hit qualification: h = valid when enable=1 and clear=0; otherwise h = 0.
- New-hit vector:
  - DEDUP=1: n = h & ~seen.
  - DEDUP=0: n = h.
- Per edge (not in reset, not clear):
  - seen <= seen | h.
  - pending <= (pending & ~pop) | n, where pop is the one-hot of the reported bit when out_valid & out_ready, else 0.
  - hit_count <= popcount(seen | h).
  - DEDUP=0: merge_count += popcount(h & pending & ~pop), saturating at 2^CNT_W-1.
- Same-edge pop and re-hit of one bit:
  - DEDUP=0: the bit stays pending, so the new hit is reported again and counts no merge.
  - DEDUP=1: no re-report, since the bit is already in seen.
- Output selection:
  - out_valid = |pending.
  - out_index = COVER_INDEX + index of the lowest set bit of pending, zero-extended to IDX_W.
  - out_index = 0 when out_valid = 0.
  - Both are decoded from registered state only; no combinational path from valid or out_ready.
- Latency: a hit on bit i at edge t gives out_valid=1 in the cycle after t, provided no lower pending bit exists.
- Ordering: lowest bit index first; a newly arriving lower bit pre-empts a higher one that has not yet been accepted.
- Stability: out_index may change while out_valid=1 only when a lower bit becomes pending; consumers must use the value present in the accept cycle.
- Throughput: one report per cycle when out_ready is held high.
- Back-pressure: with out_ready=0, reports accumulate in pending; nothing is lost.
  - DEDUP=1: capacity is WIDTH, one per point.
  - DEDUP=0: repeat hits merge into the pending bit and are counted in merge_count.
- Clear (reset=1, clear=1):
  - Zeroes seen, pending, hit_count and merge_count on that edge; valid in the same cycle is ignored.
  - A handshake in the clear cycle is still a valid transfer, but its effect is overridden by the clear.
- all_hit = &seen, registered-derived.
- enable=0: pops continue and outputs drain, but no new state is taken from valid.

Test Plan:
- Basic: WIDTH=9, COVER_INDEX=100, out_ready=1; valid=9'h001 for one cycle -> one report, out_index=100, one cycle after the edge; hit_count=1; repeat the hit -> no second report (DEDUP=1).
- Burst with back-pressure: valid=9'h1A4 (bits 2,5,7,8) in one cycle, out_ready=0 for 5 cycles then 1 -> hold out_index=102; then reports 102, 105, 107, 108 on consecutive cycles; hit_count=4; out_valid=0 afterwards.
- Pre-emption: bit 6 pending with out_ready=0; hit bit 1 -> out_index changes from 106 to 101; release out_ready -> reports 101 then 106.
- All-hit and clear: hit all 9 bits over several cycles -> hit_count=9, all_hit=1; pulse clear with valid=9'h1FF in the same cycle -> hit_count=0, all_hit=0, out_valid=0; re-hit bit 0 -> reported again.
- DEDUP=0 merging: out_ready=0; hit bit 3 on 4 cycles -> one pending report (index 103), merge_count=3; accept it while hitting bit 3 again -> one more report of 103, merge_count stays 3.
- Reset and enable: three bits pending, drive reset=0 for 1 cycle -> all outputs 0 next cycle, no stale reports; enable=0 with valid=9'h1FF -> hit_count stays 0, no reports.
